// File: rtl/fifo_pkg.sv
// Shared sizing and types for the 16-entry synchronous FIFO.
// Error flags are built only when FIFO_ERR_FLAGS_EN is defined.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef logic [DATA_WIDTH-1:0] data_ty;
  typedef logic [PTR_W-1:0]      ptr_t;
  typedef logic [CNT_W-1:0]      cnt_t;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array for sync_fifo.
// One synchronous write port, one combinational read port.
module fifo_mem
  import fifo_pkg::*;
(
  input  logic   clk,
  input  logic   we_i,
  input  ptr_t   waddr_i,
  input  data_ty wdata_i,
  input  ptr_t   raddr_i,
  output data_ty rdata_o
);

  data_ty mem_q [DEPTH];

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty status.
// Sticky overflow/underflow ports exist only with FIFO_ERR_FLAGS_EN.
module sync_fifo
  import fifo_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  data_ty data_in,
  input  logic   push,
  input  logic   pop,
  output data_ty data_out,
  output logic   full,
  output logic   empty,
  output cnt_t   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic   overflow,
  output logic   underflow
`endif
);

  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  cnt_t   count_q, count_d;
  data_ty dout_q, dout_d;
  data_ty rdata;
  logic   push_acc;
  logic   pop_acc;

  assign full  = (count_q == cnt_t'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the slot the same-cycle push lands in
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  fifo_mem u_mem (
    .clk     (clk),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
      dout_d   = rdata;
    end
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out = dout_q;
  assign count    = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  assign ovf_d = ovf_q | (push & full & ~pop_acc);
  assign udf_d = udf_q | (pop & empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo.
// Error-flag checks are built when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  data_ty data_in = '0;
  logic   push = 1'b0;
  logic   pop = 1'b0;
  data_ty data_out;
  logic   full;
  logic   empty;
  cnt_t   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic   overflow;
  logic   underflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model [$];
  logic [7:0] exp_q [$];
  logic [7:0] last_out = '0;
  bit         ovf_m = 0;
  bit         udf_m = 0;

  sync_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .push     (push),
    .pop      (pop),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("data_out", 32'(data_out), 32'(last_out));
    check("count", 32'(count), 32'(model.size()));
    check("full", 32'(full), 32'(model.size() == 16));
    check("empty", 32'(empty), 32'(model.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("underflow", 32'(underflow), 32'(udf_m));
`endif
  endtask

  task automatic cycle(input logic pu,
                       input logic po,
                       input logic [7:0] d);
    bit pok;
    bit uok;
    push    = pu;
    pop     = po;
    data_in = d;
    @(posedge clk);
    #1;
    pok = po && (model.size() > 0);
    uok = pu && ((model.size() < 16) || pok);
    if (pu && !uok) ovf_m = 1;
    if (po && model.size() == 0) udf_m = 1;
    if (pok) exp_q.push_back(model.pop_front());
    if (uok) model.push_back(d);
    if (pok) last_out = exp_q.pop_front();
    check_status();
    push = 0;
    pop  = 0;
  endtask

  initial begin
    #12;
    check_status();
    rst = 1'b1;

    // fill and drain
    for (int i = 1; i <= 16; i++) cycle(1, 0, 8'(i));
    check("full_after16", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00);
    check("drain_last", 32'(data_out), 32'd16);

    // overflow
    for (int i = 1; i <= 16; i++) cycle(1, 0, 8'(i));
    cycle(1, 0, 8'd99);
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00);

    // underflow
    cycle(0, 1, 8'h00);
    check("underflow_hold", 32'(data_out), 32'd16);

    // wrap and simultaneous push/pop
    for (int i = 0; i < 10; i++) cycle(1, 0, 8'(100 + i));
    for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00);
    for (int i = 0; i < 12; i++) cycle(1, 0, 8'(150 + i));
    for (int i = 0; i < 5; i++) cycle(1, 1, 8'(200 + i));
    check("count_12", 32'(count), 32'd12);
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'(220 + i));
    cycle(1, 1, 8'd240);
    check("full_pushpop", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00);

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(60 + i));
    #2;
    rst = 1'b0;
    #1;
    model.delete();
    last_out = '0;
    ovf_m = 0;
    udf_m = 0;
    check_status();
    #1;
    rst = 1'b1;
    cycle(0, 1, 8'h00);
    cycle(1, 0, 8'h5a);
    cycle(0, 1, 8'h00);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
